// File: rtl/inner_mem_handler.sv
// inner_mem_handler: executes one CPU load/store at a time against a
// word-addressed, byte-enabled synchronous RAM with one-cycle read latency.
// Loads are assembled little-endian and sign/zero extended into data_in.
// Optional feature macro: MISALIGNED_SPLIT_EN
//   defined   - word-crossing accesses are split into two RAM word accesses
//   undefined - misaligned accesses are forced to natural alignment and run
//               as a single access; misaligned still pulses with done
module inner_mem_handler #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  MemRW,
  input  logic [2:0]            RWType,
  input  logic [31:0]           addr_out,
  input  logic [31:0]           data_out,
  output logic [31:0]           data_in,
  output logic                  stall,
  output logic                  done,
  output logic                  misaligned,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

`ifdef MISALIGNED_SPLIT_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FIRST  = 2'd1,
    S_SECOND = 2'd2,
    S_RESP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_RESP  = 2'd3
  } state_t;
`endif

  // funct3[1:0] -> access size; 10 and 11 both mean word
  function automatic logic [1:0] size_decode(input logic [1:0] f);
    case (f)
      2'b00:   size_decode = SZ_BYTE;
      2'b01:   size_decode = SZ_HALF;
      default: size_decode = SZ_WORD;
    endcase
  endfunction

  // Byte lanes touched by an access of the given size starting at lane 0
  function automatic logic [3:0] lane_mask(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: lane_mask = 4'b0001;
      SZ_HALF: lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    is_misaligned = ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
  endfunction

  // Keep only the right-aligned bytes that the store actually writes
  function automatic logic [31:0] size_data(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_data = {24'h0, d[7:0]};
      SZ_HALF: size_data = {16'h0, d[15:0]};
      default: size_data = d;
    endcase
  endfunction

  // Sign or zero extension of the right-aligned load bytes
  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] sz,
                                         input logic uns);
    case (sz)
      SZ_BYTE: extend = uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      SZ_HALF: extend = uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

`ifndef MISALIGNED_SPLIT_EN
  // Without splitting, misaligned accesses drop to their natural alignment
  function automatic logic [1:0] align_offset(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: align_offset = off;
      SZ_HALF: align_offset = {off[1], 1'b0};
      default: align_offset = 2'b00;
    endcase
  endfunction
`endif

  state_t                  state;
  state_t                  next_state;

  logic [1:0]              in_size;
  logic [1:0]              in_off;
  logic                    in_mis;
  logic                    latch;

  logic                    store_q;
  logic                    unsigned_q;
  logic [1:0]              size_q;
  logic                    mis_q;
  logic [1:0]              off_q;
  logic [ADDR_WIDTH-1:0]   word_q;
  logic [31:0]             wdata_q;
  logic [31:0]             load_raw;

  // Byte-address bits above the RAM window are deliberately ignored
  logic                    unused_addr_hi;
  assign unused_addr_hi = ^addr_out[31:ADDR_WIDTH+2];

  assign in_size = size_decode(RWType[1:0]);
  assign in_mis  = is_misaligned(in_size, addr_out[1:0]);
  assign latch   = (state == S_IDLE) && req;

`ifdef MISALIGNED_SPLIT_EN
  logic                    in_split;
  logic                    split_q;
  logic [31:0]             low_buf;
  logic [63:0]             lane_data;
  logic [7:0]              lane_we;
  logic [63:0]             read_pair;

  assign in_off   = addr_out[1:0];
  assign in_split = ((in_size == SZ_HALF) && (addr_out[1:0] == 2'b11)) ||
                    ((in_size == SZ_WORD) && (addr_out[1:0] != 2'b00));

  // Store bytes laid out across two words; the upper word receives the spill
  assign lane_data = {32'h0, wdata_q} << {off_q, 3'b000};
  assign lane_we   = {4'h0, lane_mask(size_q)} << off_q;

  // Second word sits above the first so a right shift realigns the load bytes
  assign read_pair = split_q ? {ram_rdata, low_buf} : {32'h0, ram_rdata};
  assign load_raw  = 32'(read_pair >> {off_q, 3'b000});
`else
  logic [31:0]             lane_data;
  logic [3:0]              lane_we;

  assign in_off    = align_offset(in_size, addr_out[1:0]);
  assign lane_data = wdata_q << {off_q, 3'b000};
  assign lane_we   = lane_mask(size_q) << off_q;
  assign load_raw  = ram_rdata >> {off_q, 3'b000};
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Control fields of the request, captured when it is accepted in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q    <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= SZ_BYTE;
      mis_q      <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
      split_q    <= 1'b0;
`endif
    end else if (latch) begin
      store_q    <= MemRW;
      unsigned_q <= RWType[2];
      size_q     <= in_size;
      mis_q      <= in_mis;
`ifdef MISALIGNED_SPLIT_EN
      split_q    <= in_split;
`endif
    end
  end

  // Address and store data of the request; only consumed after acceptance
  always_ff @(posedge clk) begin
    if (latch) begin
      off_q   <= in_off;
      word_q  <= addr_out[ADDR_WIDTH+1:2];
      wdata_q <= size_data(data_out, in_size);
    end
  end

`ifdef MISALIGNED_SPLIT_EN
  // Lower word of a split load arrives while SECOND issues the upper word
  always_ff @(posedge clk) begin
    if (state == S_SECOND) begin
      low_buf <= ram_rdata;
    end
  end
`endif

  // Load result register; stores leave it untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_in <= 32'h0;
    end else if ((state == S_RESP) && !store_q) begin
      data_in <= extend(load_raw, size_q, unsigned_q);
    end
  end

  // Next-state decode and RAM strobes; the RAM is driven only in FIRST/SECOND
  always_comb begin
    next_state = state;
    ram_en     = 1'b0;
    ram_we     = 4'b0000;
    ram_addr   = '0;
    ram_wdata  = 32'h0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          next_state = S_FIRST;
        end
      end
      S_FIRST: begin
        ram_en    = 1'b1;
        ram_addr  = word_q;
        ram_we    = store_q ? lane_we[3:0] : 4'b0000;
        ram_wdata = store_q ? lane_data[31:0] : 32'h0;
`ifdef MISALIGNED_SPLIT_EN
        next_state = split_q ? S_SECOND : S_RESP;
`else
        next_state = S_RESP;
`endif
      end
`ifdef MISALIGNED_SPLIT_EN
      S_SECOND: begin
        ram_en     = 1'b1;
        ram_addr   = word_q + ADDR_WIDTH'(1);
        ram_we     = store_q ? lane_we[7:4] : 4'b0000;
        ram_wdata  = store_q ? lane_data[63:32] : 32'h0;
        next_state = S_RESP;
      end
`endif
      S_RESP: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  assign misaligned = done && mis_q;
  assign stall      = req && !done;

endmodule

// File: tb/tb_inner_mem_handler.sv
// Testbench for inner_mem_handler: byte-enabled RAM model, vector table of
// loads/stores with hand-computed results, plus reset sequences.
// Expectations follow the MISALIGNED_SPLIT_EN setting of the build.
module tb_inner_mem_handler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        MemRW;
  logic [2:0]  RWType;
  logic [31:0] addr_out;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        stall;
  logic        done;
  logic        misaligned;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;

  int checks   = 0;
  int failures = 0;

  inner_mem_handler #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .MemRW(MemRW), .RWType(RWType),
    .addr_out(addr_out), .data_out(data_out), .data_in(data_in), .stall(stall),
    .done(done), .misaligned(misaligned), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model with write log
  logic [31:0] mem [0:1023];
  logic [9:0]  wa_log [0:255];
  logic [3:0]  we_log [0:255];
  logic [31:0] wd_log [0:255];
  logic [7:0]  wr_total = 8'd0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we != 4'b0000) begin
        mem[ram_addr]    <= merge(mem[ram_addr], ram_wdata, ram_we);
        wa_log[wr_total] <= ram_addr;
        we_log[wr_total] <= ram_we;
        wd_log[wr_total] <= ram_wdata;
        wr_total         <= wr_total + 8'd1;
      end
    end
  end

  typedef struct packed {
    logic        rw;
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    logic        mis;
    logic [7:0]  lat;
    logic [7:0]  nw;
    logic [9:0]  wa0;
    logic [3:0]  we0;
    logic [31:0] wd0;
    logic [9:0]  wa1;
    logic [3:0]  we1;
    logic [31:0] wd1;
  } vec_t;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  function automatic vec_t ld(input logic [2:0] t, input logic [31:0] a, input logic [31:0] e,
                              input logic m, input logic [7:0] l);
    vec_t v;
    v = '0;
    v.rw = 1'b0; v.t = t; v.a = a; v.exp = e; v.mis = m; v.lat = l;
    return v;
  endfunction

  function automatic vec_t st(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                              input logic m, input logic [7:0] l, input logic [7:0] nw,
                              input logic [9:0] wa0, input logic [3:0] we0, input logic [31:0] wd0,
                              input logic [9:0] wa1, input logic [3:0] we1, input logic [31:0] wd1);
    vec_t v;
    v = '0;
    v.rw = 1'b1; v.t = t; v.a = a; v.d = d; v.mis = m; v.lat = l; v.nw = nw;
    v.wa0 = wa0; v.we0 = we0; v.wd0 = wd0; v.wa1 = wa1; v.we1 = we1; v.wd1 = wd1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start_req(input logic rw, input logic [2:0] t, input logic [31:0] a,
                           input logic [31:0] d);
    @(negedge clk);
    MemRW = rw; RWType = t; addr_out = a; data_out = d; req = 1'b1;
  endtask

  // Cycle 0 is the cycle in which req is first seen in IDLE
  task automatic wait_done(output int lat, output logic mis, output logic stall_ok);
    logic got;
    got = 1'b0; lat = -1; mis = 1'b0; stall_ok = 1'b1;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (!got) begin
        if (done === 1'b1) begin
          got = 1'b1; lat = c; mis = misaligned;
          if (stall !== 1'b0) stall_ok = 1'b0;
        end else begin
          if (stall !== 1'b1) stall_ok = 1'b0;
          @(negedge clk);
          #1;
        end
      end
    end
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  vec_t        vq[$];
  vec_t        v;
  int          lat;
  logic        mis;
  logic        sok;
  logic [7:0]  base;
  logic [7:0]  nw;
  logic [31:0] last_load;
  logic [31:0] rst_a, rst_exp, rst_mid_addr;
  int          rst_lat;
  logic        rst_mis;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; MemRW = 1'b0; RWType = 3'b000;
    addr_out = 32'h0; data_out = 32'h0;

    // Shared vectors: identical result in both builds
    vq.push_back(st(SW,  32'h100,  32'h8899AABB, 0, 2, 1, 10'h040, 4'b1111, 32'h8899AABB, 0, 0, 0));
    vq.push_back(ld(LB,  32'h101,  32'hFFFFFFAA, 0, 2));
    vq.push_back(ld(LBU, 32'h101,  32'h000000AA, 0, 2));
    vq.push_back(ld(LB,  32'h103,  32'hFFFFFF88, 0, 2));
    vq.push_back(ld(LBU, 32'h102,  32'h00000099, 0, 2));
    vq.push_back(ld(LH,  32'h100,  32'hFFFFAABB, 0, 2));
    vq.push_back(ld(LHU, 32'h102,  32'h00008899, 0, 2));
    vq.push_back(ld(LW,  32'h100,  32'h8899AABB, 0, 2));
    vq.push_back(st(SH,  32'h102,  32'hFFFF1234, 0, 2, 1, 10'h040, 4'b1100, 32'h12340000, 0, 0, 0));
    vq.push_back(ld(LW,  32'h100,  32'h1234AABB, 0, 2));
    vq.push_back(st(SB,  32'h101,  32'h77777755, 0, 2, 1, 10'h040, 4'b0010, 32'h00005500, 0, 0, 0));
    vq.push_back(ld(LW,  32'hFFFFF100, 32'h123455BB, 0, 2));
    vq.push_back(st(SW,  32'hFFC,  32'h11223344, 0, 2, 1, 10'h3FF, 4'b1111, 32'h11223344, 0, 0, 0));
    vq.push_back(st(SW,  32'h000,  32'h556677E8, 0, 2, 1, 10'h000, 4'b1111, 32'h556677E8, 0, 0, 0));
    vq.push_back(ld(LW,  32'hFFC,  32'h11223344, 0, 2));
    vq.push_back(ld(LB,  32'h000,  32'hFFFFFFE8, 0, 2));
    vq.push_back(ld(3'b011, 32'h000, 32'h556677E8, 0, 2));
    vq.push_back(st(3'b110, 32'h104, 32'h0BADF00D, 0, 2, 1, 10'h041, 4'b1111, 32'h0BADF00D, 0, 0, 0));
    vq.push_back(ld(LW,  32'h104,  32'h0BADF00D, 0, 2));
    vq.push_back(ld(LHU, 32'h106,  32'h00000BAD, 0, 2));
    vq.push_back(ld(LH,  32'h104,  32'hFFFFF00D, 0, 2));
`ifdef MISALIGNED_SPLIT_EN
    vq.push_back(st(SW,  32'h102,  32'hAABBCCDD, 1, 3, 2, 10'h040, 4'b1100, 32'hCCDD0000,
                    10'h041, 4'b0011, 32'h0000AABB));
    vq.push_back(ld(LW,  32'h102,  32'hAABBCCDD, 1, 3));
    vq.push_back(ld(LH,  32'h103,  32'hFFFFBBCC, 1, 3));
    vq.push_back(ld(LH,  32'h101,  32'hFFFFDD55, 1, 2));
    vq.push_back(ld(LHU, 32'h103,  32'h0000BBCC, 1, 3));
    vq.push_back(ld(LH,  32'hFFF,  32'hFFFFE811, 1, 3));
    vq.push_back(st(SH,  32'hFFF,  32'h0000A1B2, 1, 3, 2, 10'h3FF, 4'b1000, 32'hB2000000,
                    10'h000, 4'b0001, 32'h000000A1));
    vq.push_back(ld(LW,  32'hFFC,  32'hB2223344, 0, 2));
    vq.push_back(ld(LW,  32'h000,  32'h556677A1, 0, 2));
    vq.push_back(ld(LW,  32'h101,  32'hBBCCDD55, 1, 3));
    rst_a = 32'h102; rst_exp = 32'hAABBCCDD; rst_lat = 3; rst_mis = 1'b1; rst_mid_addr = 32'h041;
`else
    vq.push_back(ld(LW,  32'h102,  32'h123455BB, 1, 2));
    vq.push_back(ld(LH,  32'h103,  32'h00001234, 1, 2));
    vq.push_back(ld(LHU, 32'h105,  32'h0000F00D, 1, 2));
    vq.push_back(st(SW,  32'h103,  32'hCAFEF00D, 1, 2, 1, 10'h040, 4'b1111, 32'hCAFEF00D, 0, 0, 0));
    vq.push_back(st(SH,  32'h107,  32'h0000BEEF, 1, 2, 1, 10'h041, 4'b1100, 32'hBEEF0000, 0, 0, 0));
    vq.push_back(ld(LH,  32'h101,  32'hFFFFF00D, 1, 2));
    vq.push_back(ld(LW,  32'h104,  32'hBEEFF00D, 0, 2));
    vq.push_back(ld(LW,  32'hFFF,  32'h11223344, 1, 2));
    rst_a = 32'h100; rst_exp = 32'hCAFEF00D; rst_lat = 2; rst_mis = 1'b0; rst_mid_addr = 32'h040;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    req = 1'b1;
    #1;
    chk("rst_stall_req1", {31'h0, stall}, 32'h1);
    req = 1'b0;
    #1;
    chk("rst_stall_req0", {31'h0, stall},      32'h0);
    chk("rst_data_in",    data_in,             32'h0);
    chk("rst_done",       {31'h0, done},       32'h0);
    chk("rst_misaligned", {31'h0, misaligned}, 32'h0);
    chk("rst_ram_en",     {31'h0, ram_en},     32'h0);
    chk("rst_ram_we",     {28'h0, ram_we},     32'h0);
    chk("rst_ram_addr",   {22'h0, ram_addr},   32'h0);
    chk("rst_ram_wdata",  ram_wdata,           32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table, issued back to back
    last_load = 32'h0;
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      base = wr_total;
      start_req(v.rw, v.t, v.a, v.d);
      wait_done(lat, mis, sok);
      nw = wr_total - base;
      if (!v.rw) last_load = v.exp;
      chk($sformatf("v%0d_latency", i),    32'(lat),          32'(v.lat));
      chk($sformatf("v%0d_misaligned", i), {31'h0, mis},      {31'h0, v.mis});
      chk($sformatf("v%0d_stall", i),      {31'h0, sok},      32'h1);
      chk($sformatf("v%0d_data_in", i),    data_in,           last_load);
      chk($sformatf("v%0d_writes", i),     {24'h0, nw},       {24'h0, v.nw});
      if (v.nw >= 8'd1 && nw >= 8'd1) begin
        chk($sformatf("v%0d_w0_addr", i),  {22'h0, wa_log[base]}, {22'h0, v.wa0});
        chk($sformatf("v%0d_w0_we", i),    {28'h0, we_log[base]}, {28'h0, v.we0});
        chk($sformatf("v%0d_w0_data", i),  wd_log[base],          v.wd0);
      end
      if (v.nw >= 8'd2 && nw >= 8'd2) begin
        chk($sformatf("v%0d_w1_addr", i),  {22'h0, wa_log[base + 8'd1]}, {22'h0, v.wa1});
        chk($sformatf("v%0d_w1_we", i),    {28'h0, we_log[base + 8'd1]}, {28'h0, v.we1});
        chk($sformatf("v%0d_w1_data", i),  wd_log[base + 8'd1],          v.wd1);
      end
    end

    // Reset pulled in the middle of a transaction, request held throughout
    start_req(1'b0, LW, rst_a, 32'h0);
    @(posedge clk);
`ifdef MISALIGNED_SPLIT_EN
    @(posedge clk);
`endif
    #2;
    chk("mid_ram_en",   {31'h0, ram_en},   32'h1);
    chk("mid_ram_addr", {22'h0, ram_addr}, rst_mid_addr);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ram_en",     {31'h0, ram_en},     32'h0);
    chk("mid_rst_ram_we",     {28'h0, ram_we},     32'h0);
    chk("mid_rst_ram_addr",   {22'h0, ram_addr},   32'h0);
    chk("mid_rst_ram_wdata",  ram_wdata,           32'h0);
    chk("mid_rst_data_in",    data_in,             32'h0);
    chk("mid_rst_done",       {31'h0, done},       32'h0);
    chk("mid_rst_misaligned", {31'h0, misaligned}, 32'h0);
    chk("mid_rst_stall",      {31'h0, stall},      32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(lat, mis, sok);
    chk("post_rst_latency",    32'(lat),     32'(rst_lat));
    chk("post_rst_misaligned", {31'h0, mis}, {31'h0, rst_mis});
    chk("post_rst_stall",      {31'h0, sok}, 32'h1);
    chk("post_rst_data_in",    data_in,      rst_exp);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
